// File: rtl/ibuf_predecode.sv
// ibuf_predecode: multi-issue instruction buffer between fetch and decode.
//
// Fetch writes up to IN_W instructions per cycle into a circular buffer.
// Each word is predecoded on write into a branch/jump bit (br) and a
// delay-slot bit (ds). Decode sees up to OUT_W of the oldest entries in
// program order. A branch is never presented unless its delay slot is
// presented in the same group.
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   flush               drop all entries (takes priority over writes and takes)
//   in_valid/inst/pc    fetch group, lane 0 oldest, valid bits contiguous from lane 0
//   in_ready            a full IN_W group fits, judged from the registered count
//   out_valid/inst/pc   oldest entries, lane 0 oldest, zero on invalid lanes
//   out_branch, out_ds  predecode bits of the presented entries
//   out_take            number of lanes consumed this cycle, counted from lane 0
//   count               current occupancy
module ibuf_predecode #(
    parameter int DEPTH = 8,
    parameter int IN_W  = 2,
    parameter int OUT_W = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         flush,
    input  logic [IN_W-1:0]              in_valid,
    input  logic [32*IN_W-1:0]           in_inst,
    input  logic [32*IN_W-1:0]           in_pc,
    output logic                         in_ready,
    output logic [OUT_W-1:0]             out_valid,
    output logic [32*OUT_W-1:0]          out_inst,
    output logic [32*OUT_W-1:0]          out_pc,
    output logic [OUT_W-1:0]             out_branch,
    output logic [OUT_W-1:0]             out_ds,
    input  logic [$clog2(OUT_W+1)-1:0]   out_take,
    output logic [$clog2(DEPTH+1)-1:0]   count
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);
    localparam int TW = $clog2(OUT_W+1);
    localparam int NW = $clog2(IN_W+1);

    logic [31:0]      r_inst [DEPTH];
    logic [31:0]      r_pc   [DEPTH];
    logic [DEPTH-1:0] r_br;
    logic [DEPTH-1:0] r_ds;
    logic [PW-1:0]    r_wr_ptr;
    logic [PW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             r_last_br;

    logic [IN_W-1:0]  w_in_br;
    logic [IN_W-1:0]  w_in_ds;
    logic [NW-1:0]    w_nin;
    logic             w_wr_en;
    logic             w_last_br_nxt;
    logic [TW-1:0]    w_nvld;
    logic [TW-1:0]    w_ntake;
    logic [PW-1:0]    w_idx [OUT_W];
    logic [OUT_W-1:0] w_lane_ok;

    assign count    = r_count;
    assign in_ready = (CW'(DEPTH) - r_count) >= CW'(IN_W);
    assign w_wr_en  = in_ready && (|in_valid) && !flush;

    // Predecode. A lane's delay-slot bit comes from the lane before it, or
    // from the last entry of the previous accepted group for lane 0.
    for (genvar k = 0; k < IN_W; k++) begin : g_pd
        logic [5:0] w_op;
        logic [4:0] w_rt;
        logic [5:0] w_fn;
        assign w_op = in_inst[32*k+26 +: 6];
        assign w_rt = in_inst[32*k+16 +: 5];
        assign w_fn = in_inst[32*k    +: 6];
        assign w_in_br[k] = (w_op >= 6'd2 && w_op <= 6'd7) ||
                            (w_op == 6'd1 && (w_rt == 5'd0  || w_rt == 5'd1 ||
                                              w_rt == 5'd16 || w_rt == 5'd17)) ||
                            (w_op == 6'd0 && (w_fn == 6'd8 || w_fn == 6'd9));
        if (k == 0) begin : g_first
            assign w_in_ds[k] = r_last_br;
        end else begin : g_rest
            assign w_in_ds[k] = w_in_br[k-1];
        end
    end

    // Output lanes. A branch needs its delay slot resident and inside the
    // issue window; the first lane that fails hides itself and every later lane.
    for (genvar i = 0; i < OUT_W; i++) begin : g_out
        localparam bit BR_LANE = (OUT_W < 2) || (i < OUT_W-1);
        assign w_idx[i]     = r_rd_ptr + PW'(i);
        assign w_lane_ok[i] = (CW'(i) < r_count) &&
                              (!r_br[w_idx[i]] || (BR_LANE && (CW'(i+1) < r_count)));
        assign out_valid[i]          = &w_lane_ok[i:0];
        assign out_inst[32*i +: 32]  = out_valid[i] ? r_inst[w_idx[i]] : 32'd0;
        assign out_pc[32*i +: 32]    = out_valid[i] ? r_pc[w_idx[i]]   : 32'd0;
        assign out_branch[i]         = out_valid[i] & r_br[w_idx[i]];
        assign out_ds[i]             = out_valid[i] & r_ds[w_idx[i]];
    end

    always_comb begin
        w_nin         = '0;
        w_last_br_nxt = r_last_br;
        for (int k = 0; k < IN_W; k++) begin
            w_nin = w_nin + NW'(in_valid[k]);
            if (in_valid[k]) w_last_br_nxt = w_in_br[k];
        end
        w_nvld = '0;
        for (int i = 0; i < OUT_W; i++) w_nvld = w_nvld + TW'(out_valid[i]);
        // Over-take is a consumer error; clamp so the state stays consistent.
        w_ntake = (out_take < w_nvld) ? out_take : w_nvld;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int e = 0; e < DEPTH; e++) begin
                r_inst[e] <= '0;
                r_pc[e]   <= '0;
            end
            r_br      <= '0;
            r_ds      <= '0;
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_count   <= '0;
            r_last_br <= 1'b0;
        end else if (flush) begin
            // Storage is left stale; count=0 masks it.
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_count   <= '0;
            r_last_br <= 1'b0;
        end else begin
            if (w_wr_en) begin
                for (int k = 0; k < IN_W; k++) begin
                    if (in_valid[k]) begin
                        r_inst[r_wr_ptr + PW'(k)] <= in_inst[32*k +: 32];
                        r_pc[r_wr_ptr + PW'(k)]   <= in_pc[32*k +: 32];
                        r_br[r_wr_ptr + PW'(k)]   <= w_in_br[k];
                        r_ds[r_wr_ptr + PW'(k)]   <= w_in_ds[k];
                    end
                end
                r_wr_ptr  <= r_wr_ptr + PW'(w_nin);
                r_last_br <= w_last_br_nxt;
            end
            r_rd_ptr <= r_rd_ptr + PW'(w_ntake);
            r_count  <= r_count + (w_wr_en ? CW'(w_nin) : CW'(0)) - CW'(w_ntake);
        end
    end
endmodule

// File: tb/tb_ibuf_predecode.sv
// Self-checking bench for ibuf_predecode: directed scenarios plus a random
// run, all compared against a queue-based reference model.
module tb_ibuf_predecode;
    localparam int DP = 8;
    localparam int IW = 2;
    localparam int OW = 2;
    localparam int CW = $clog2(DP+1);
    localparam int TW = $clog2(OW+1);
    localparam int VW = CW + 1 + 3*OW + 64*OW;

    logic              clk = 0;
    logic              rst;
    logic              flush;
    logic [IW-1:0]     in_valid;
    logic [32*IW-1:0]  in_inst, in_pc;
    logic              in_ready;
    logic [OW-1:0]     out_valid, out_branch, out_ds;
    logic [32*OW-1:0]  out_inst, out_pc;
    logic [TW-1:0]     out_take;
    logic [CW-1:0]     count;

    int n_vec = 0;
    int n_bad = 0;

    ibuf_predecode #(.DEPTH(DP), .IN_W(IW), .OUT_W(OW)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_inst(in_inst), .in_pc(in_pc), .in_ready(in_ready),
        .out_valid(out_valid), .out_inst(out_inst), .out_pc(out_pc),
        .out_branch(out_branch), .out_ds(out_ds), .out_take(out_take), .count(count)
    );

    always #5 clk = ~clk;

    // Consumer contract: never take more lanes than are presented.
    always @(posedge clk)
        if (!rst && !flush)
            assert (out_take <= $countones(out_valid))
            else $error("out_take %0d exceeds valid lanes %b", out_take, out_valid);

    // ---------------- reference model ----------------
    typedef struct {
        logic [31:0] inst;
        logic [31:0] pc;
        bit          br;
        bit          ds;
    } ent_t;

    ent_t q[$];
    bit   m_last_br;

    function automatic bit m_isbr(input logic [31:0] w);
        case (w[31:26])
            6'd0:    return (w[5:0] == 6'd8) || (w[5:0] == 6'd9);
            6'd1:    return w[20:16] inside {5'd0, 5'd1, 5'd16, 5'd17};
            6'd2, 6'd3, 6'd4, 6'd5, 6'd6, 6'd7: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    // Oldest entries issue until a branch whose delay slot is missing or
    // would land outside the issue group.
    function automatic int m_nvalid();
        int n = 0;
        for (int i = 0; i < OW && i < q.size(); i++) begin
            if (q[i].br && !((i + 1 < q.size()) && (OW < 2 || i < OW - 1))) break;
            n++;
        end
        return n;
    endfunction

    function automatic logic [VW-1:0] mdl_vec();
        logic [OW-1:0]    v, b, d;
        logic [32*OW-1:0] ins, pcs;
        int n;
        v = '0; b = '0; d = '0; ins = '0; pcs = '0;
        n = m_nvalid();
        for (int i = 0; i < n; i++) begin
            v[i] = 1'b1;
            b[i] = q[i].br;
            d[i] = q[i].ds;
            ins[32*i +: 32] = q[i].inst;
            pcs[32*i +: 32] = q[i].pc;
        end
        return {CW'(q.size()), (DP - q.size() >= IW), v, b, d, ins, pcs};
    endfunction

    function automatic logic [VW-1:0] dut_vec();
        return {count, in_ready, out_valid, out_branch, out_ds, out_inst, out_pc};
    endfunction

    // One clock: drive inputs, advance the model at the edge, settle 1 time unit.
    task automatic cyc(input bit fl, input logic [IW-1:0] iv,
                       input logic [32*IW-1:0] ii, input logic [32*IW-1:0] ip,
                       input int tk);
        int nv, nt;
        bit rdy;
        ent_t e;
        flush = fl; in_valid = iv; in_inst = ii; in_pc = ip; out_take = TW'(tk);
        nv  = m_nvalid();
        rdy = (DP - q.size() >= IW);
        @(posedge clk);
        if (fl) begin
            q.delete();
            m_last_br = 0;
        end else begin
            nt = (tk < nv) ? tk : nv;
            repeat (nt) void'(q.pop_front());
            if (rdy && iv != 0)
                for (int k = 0; k < IW; k++)
                    if (iv[k]) begin
                        e.inst = ii[32*k +: 32];
                        e.pc   = ip[32*k +: 32];
                        e.br   = m_isbr(e.inst);
                        e.ds   = m_last_br;
                        m_last_br = e.br;
                        q.push_back(e);
                    end
        end
        #1;
        flush = 0; in_valid = '0; out_take = '0;
    endtask

    task automatic drain();
        for (int g = 0; g < 2*DP && q.size() != 0; g++) cyc(0, '0, '0, '0, m_nvalid());
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        n_vec++;
        if (count !== 0 || in_ready !== 1'b1 || out_valid !== '0 || out_inst !== '0) begin
            n_bad++;
            $display("FAIL reset: count=%0d rdy=%b vld=%b inst=%h want 0/1/0/0",
                     count, in_ready, out_valid, out_inst);
        end
        n_vec++;
        if (dut_vec() !== mdl_vec()) begin
            n_bad++;
            $display("FAIL reset_vec got %h want %h", dut_vec(), mdl_vec());
        end
    endtask

    task automatic test_pair();
        cyc(0, 2'b11, {32'h00851021, 32'h00851021}, {32'hBFC00004, 32'hBFC00000}, 0);
        n_vec++;
        if (out_valid !== 2'b11 || out_branch !== 2'b00 || out_pc[63:32] !== 32'hBFC00004) begin
            n_bad++;
            $display("FAIL pair_out: vld=%b br=%b pc1=%h want 11/00/bfc00004",
                     out_valid, out_branch, out_pc[63:32]);
        end
        cyc(0, '0, '0, '0, 2);
        n_vec++;
        if (count !== 0) begin
            n_bad++;
            $display("FAIL pair_take: count=%0d want 0", count);
        end
    endtask

    task automatic test_delay_slot();
        cyc(0, 2'b01, {32'h0, 32'h10850003}, {32'h0, 32'hBFC00008}, 0);
        n_vec++;
        if (out_valid !== 2'b00) begin
            n_bad++;
            $display("FAIL ds_hold: vld=%b want 00", out_valid);
        end
        cyc(0, 2'b01, {32'h0, 32'h00000000}, {32'h0, 32'hBFC0000C}, 0);
        n_vec++;
        if (out_valid !== 2'b11 || out_branch !== 2'b01 || out_ds !== 2'b10) begin
            n_bad++;
            $display("FAIL ds_pair: vld=%b br=%b ds=%b want 11/01/10",
                     out_valid, out_branch, out_ds);
        end
        drain();
    endtask

    task automatic test_branch_lane();
        cyc(0, 2'b11, {32'h14850002, 32'h00851021}, {32'hBFC00014, 32'hBFC00010}, 0);
        cyc(0, 2'b01, {32'h0, 32'h00000000}, {32'h0, 32'hBFC00018}, 0);
        n_vec++;
        if (out_valid !== 2'b01) begin
            n_bad++;
            $display("FAIL brlane_block: vld=%b want 01", out_valid);
        end
        cyc(0, '0, '0, '0, 1);
        n_vec++;
        if (out_valid !== 2'b11 || out_inst[31:0] !== 32'h14850002 || out_ds !== 2'b10) begin
            n_bad++;
            $display("FAIL brlane_shift: vld=%b inst0=%h ds=%b want 11/14850002/10",
                     out_valid, out_inst[31:0], out_ds);
        end
        drain();
    endtask

    task automatic test_fill_wrap();
        logic [31:0] pc, prev0;
        pc = 32'h8000_0100;
        for (int c = 0; c < 4; c++) begin
            cyc(0, 2'b11, {32'h00851021, 32'h00851021}, {pc + 32'd4, pc}, 0);
            pc += 8;
        end
        n_vec++;
        if (count !== 4'd8 || in_ready !== 1'b0) begin
            n_bad++;
            $display("FAIL fill_full: count=%0d rdy=%b want 8/0", count, in_ready);
        end
        cyc(0, 2'b11, {32'h00851021, 32'h00851021}, {32'hDEAD0004, 32'hDEAD0000}, 0);
        n_vec++;
        if (count !== 4'd8) begin
            n_bad++;
            $display("FAIL fill_drop: count=%0d want 8", count);
        end
        prev0 = out_pc[31:0] - 32'd8;
        for (int c = 0; c < 6; c++) begin
            logic acc;
            acc = (DP - q.size() >= IW);
            cyc(0, 2'b11, {32'h00851021, 32'h00851021}, {pc + 32'd4, pc}, 2);
            if (acc) pc += 8;
            n_vec++;
            if (out_pc[31:0] !== prev0 + 32'd16 || out_pc[63:32] !== out_pc[31:0] + 32'd4
                || dut_vec() !== mdl_vec()) begin
                n_bad++;
                $display("FAIL wrap_seq c=%0d pc0=%h pc1=%h want pc0=%h", c,
                         out_pc[31:0], out_pc[63:32], prev0 + 32'd16);
            end
            prev0 = out_pc[31:0] - 32'd8;
        end
        drain();
    endtask

    task automatic test_flush();
        cyc(0, 2'b11, {32'h0C000100, 32'h00851021}, {32'h80000204, 32'h80000200}, 0);
        cyc(1, 2'b11, {32'h00851021, 32'h00851021}, {32'h80000304, 32'h80000300}, 2);
        n_vec++;
        if (count !== 0 || out_valid !== 2'b00) begin
            n_bad++;
            $display("FAIL flush_clear: count=%0d vld=%b want 0/00", count, out_valid);
        end
        cyc(0, 2'b01, {32'h0, 32'h00851021}, {32'h0, 32'h80000400}, 0);
        n_vec++;
        if (out_valid !== 2'b01 || out_ds !== 2'b00) begin
            n_bad++;
            $display("FAIL flush_ds: vld=%b ds=%b want 01/00", out_valid, out_ds);
        end
        drain();
    endtask

    task automatic test_async_reset();
        cyc(0, 2'b11, {32'h08000040, 32'h00851021}, {32'h80000504, 32'h80000500}, 0);
        rst = 1;
        #2;
        n_vec++;
        if (count !== 0 || out_valid !== 2'b00 || in_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL async_rst: count=%0d vld=%b rdy=%b want 0/00/1",
                     count, out_valid, in_ready);
        end
        rst = 0;
        q.delete();
        m_last_br = 0;
        @(posedge clk); #1;
        cyc(0, 2'b01, {32'h0, 32'h00851021}, {32'h0, 32'h80000600}, 0);
        n_vec++;
        if (out_ds !== 2'b00 || out_valid !== 2'b01) begin
            n_bad++;
            $display("FAIL async_rst_ds: vld=%b ds=%b want 01/00", out_valid, out_ds);
        end
        drain();
    endtask

    function automatic logic [31:0] rnd_inst();
        logic [31:0] w;
        w = $urandom;
        w[31:26] = 6'($urandom_range(0, 9));
        if ($urandom_range(0, 1) == 1) w[20:16] = 5'($urandom_range(0, 1) * 16 + $urandom_range(0, 1));
        if ($urandom_range(0, 1) == 1) w[5:0] = 6'($urandom_range(8, 9));
        return w;
    endfunction

    task automatic test_random();
        logic [IW-1:0]    iv;
        logic [32*IW-1:0] ii, ip;
        for (int c = 0; c < 400; c++) begin
            case ($urandom_range(0, 2))
                0:       iv = 2'b00;
                1:       iv = 2'b01;
                default: iv = 2'b11;
            endcase
            ii = {rnd_inst(), rnd_inst()};
            ip = {32'($urandom), 32'($urandom)};
            cyc(($urandom_range(0, 24) == 0), iv, ii, ip, $urandom_range(0, m_nvalid()));
            n_vec++;
            if (dut_vec() !== mdl_vec()) begin
                n_bad++;
                $display("FAIL random c=%0d got %h want %h", c, dut_vec(), mdl_vec());
            end
        end
        drain();
    endtask

    initial begin
        rst = 1; flush = 0; in_valid = '0; in_inst = '0; in_pc = '0; out_take = '0;
        m_last_br = 0;
        #17;
        test_reset();
        rst = 0;
        @(posedge clk); #1;
        test_pair();
        test_delay_slot();
        test_branch_lane();
        test_fill_wrap();
        test_flush();
        test_async_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
